// File: rtl/tx_burst_ctrl.sv
// tx_burst_ctrl: burst scheduler for the 16-QAM transmit chain.
// It sequences each burst as PREAMBLE -> PAYLOAD -> GUARD on one clock domain.
// It also produces the sample phase, the per-bit shift enable and the per-symbol
// strobe that the bit source and the pulse-shaping filter need.
//
// Interface contract: start is a level request that is sampled only in IDLE,
// and it is never queued. done is a one-cycle completion pulse on the last
// cycle of GUARD. At that same edge continuous alone decides whether the next
// burst follows back-to-back. sym_in must hold a complete symbol whenever
// sym_en is high. The bit source provides this because bit_en fires BIT_SYM
// times per payload symbol.
module tx_burst_ctrl #(
   parameter int SPS       = 8,
   parameter int BIT_SYM   = 4,
   parameter int PRE_LEN   = 16,
   parameter int GUARD_LEN = 8,
   parameter int LEN_W     = 10
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    start,
   input  logic                    continuous,
   input  logic [LEN_W-1:0]        payload_len,
   input  logic [BIT_SYM-1:0]      sym_in,
   output logic [$clog2(SPS)-1:0]  count,
   output logic                    bit_en,
   output logic                    sym_en,
   output logic [BIT_SYM-1:0]      symbol,
   output logic                    tx_on,
   output logic                    busy,
   output logic [1:0]              state,
   output logic                    done
);

   localparam int CNT_W   = $clog2(SPS);
   localparam int BIT_DIV = SPS / BIT_SYM;
   localparam int PRE_IW  = $clog2(PRE_LEN);
   localparam int GRD_IW  = (GUARD_LEN > 1) ? $clog2(GUARD_LEN) : 1;
   localparam int IDX_A   = (PRE_IW > GRD_IW) ? PRE_IW : GRD_IW;
   localparam int IDX_W   = (IDX_A > LEN_W) ? IDX_A : LEN_W;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SPS - 1);
   localparam logic [IDX_W-1:0] PRE_LAST = IDX_W'(PRE_LEN - 1);
   localparam logic [IDX_W-1:0] GRD_LAST = IDX_W'(GUARD_LEN - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_PRE   = 2'b01,
      ST_PAY   = 2'b10,
      ST_GUARD = 2'b11
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic [BIT_SYM-1:0] symbol_q, symbol_d;

   logic [IDX_W-1:0]   len_ext;
   logic               pay_last;
   logic               bit_phase;
   logic               bit_win;

   // Decode strobes and status purely from registered state so they are glitch-free
   // and drop to zero the instant reset clears the registers.
   always_comb begin
      busy      = (state_q != ST_IDLE);
      tx_on     = (state_q == ST_PRE) || (state_q == ST_PAY);
      sym_en    = busy && (count_q == CNT_LAST);
      len_ext   = IDX_W'(len_q);
      pay_last  = (idx_q == (len_ext - IDX_W'(1)));
      bit_phase = ((32'(count_q) % BIT_DIV) == (BIT_DIV - 1));
      // Shifting in the last preamble symbol preloads the first payload symbol.
      // The last payload symbol needs no shifts because nothing follows it.
      bit_win   = ((state_q == ST_PRE) && (idx_q == PRE_LAST)) ||
                  ((state_q == ST_PAY) && !pay_last);
      bit_en    = bit_win && bit_phase;
      done      = (state_q == ST_GUARD) && (idx_q == GRD_LAST) && sym_en;
      state     = state_q;
      count     = count_q;
      symbol    = symbol_q;
   end

   // Compute the next sample phase, burst state, symbol index, latched length and symbol.
   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      idx_d    = idx_q;
      len_d    = len_q;
      symbol_d = symbol_q;

      if (state_q == ST_IDLE) begin
         count_d = '0;
      end else if (count_q == CNT_LAST) begin
         count_d = '0;
      end else begin
         count_d = count_q + CNT_W'(1);
      end

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d  = ST_PRE;
               count_d  = '0;
               idx_d    = '0;
               symbol_d = '0;
               len_d    = payload_len;
            end
         end
         ST_PRE: begin
            if (sym_en) begin
               if (idx_q == PRE_LAST) begin
                  idx_d = '0;
                  if (len_q != '0) begin
                     state_d  = ST_PAY;
                     symbol_d = sym_in;
                  end else begin
                     state_d  = ST_GUARD;
                     symbol_d = '0;
                  end
               end else begin
                  idx_d = idx_q + IDX_W'(1);
                  // The next index has the opposite parity. An odd index selects
                  // the all-ones corner point.
                  symbol_d = idx_q[0] ? '0 : '1;
               end
            end
         end
         ST_PAY: begin
            if (sym_en) begin
               if (pay_last) begin
                  state_d  = ST_GUARD;
                  symbol_d = '0;
                  idx_d    = '0;
               end else begin
                  symbol_d = sym_in;
                  idx_d    = idx_q + IDX_W'(1);
               end
            end
         end
         ST_GUARD: begin
            if (sym_en) begin
               if (idx_q == GRD_LAST) begin
                  idx_d    = '0;
                  symbol_d = '0;
                  if (continuous) begin
                     state_d = ST_PRE;
                     len_d   = payload_len;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State registers with asynchronous active-low clear. An interrupted burst is dropped.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q  <= ST_IDLE;
         count_q  <= '0;
         idx_q    <= '0;
         len_q    <= '0;
         symbol_q <= '0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         idx_q    <= idx_d;
         len_q    <= len_d;
         symbol_q <= symbol_d;
      end
   end

endmodule
